// File: rtl/uart_alu_if_if.sv
// Bundles the byte-level UART/ALU handshake signals of uart_alu_if.
// The slave modport is the frame controller; the master modport is the surrounding UART and ALU.
interface uart_alu_if_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rxdone;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_error;

    modport slave (
        input  i_rx_data, i_rxdone, i_alu_result, i_tx_done,
        output o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy, o_error
    );

    modport master (
        output i_rx_data, i_rxdone, i_alu_result, i_tx_done,
        input  o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy, o_error
    );
endinterface

// File: rtl/uart_alu_if.sv
// Collects operand A, operand B and opcode bytes from a UART receiver, then sends the ALU result back.
// Frames abort with a one-cycle error pulse on an unknown opcode or when the link goes idle too long.
module uart_alu_if #(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int NB_TIMEOUT  = 20
) (
    input logic           clk,
    input logic           i_rst_n,
    uart_alu_if_if.slave  bus
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        SEND,
        WAIT_TX
    } state_t;

    // The abort is registered on the edge where the count would reach TIMEOUT_CYC-1.
    localparam logic [NB_TIMEOUT-1:0] TO_LAST = NB_TIMEOUT'(TIMEOUT_CYC - 2);

    state_t              state, state_next;
    logic [NB_TIMEOUT-1:0] cnt, cnt_next, cnt_inc;
    logic [NB_DATA-1:0]  data_a, data_a_next;
    logic [NB_DATA-1:0]  data_b, data_b_next;
    logic [NB_OP-1:0]    op, op_next;
    logic [NB_DATA-1:0]  tx_data, tx_data_next;
    logic                tx_start, tx_start_next;
    logic                error, error_next;
    logic                timeout;
    logic [NB_OP-1:0]    rx_op;

    function automatic logic op_valid(input logic [NB_OP-1:0] code);
        case (code)
            NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100),
            NB_OP'(6'b100101), NB_OP'(6'b100110), NB_OP'(6'b100111),
            NB_OP'(6'b000011), NB_OP'(6'b000010): op_valid = 1'b1;
            default:                              op_valid = 1'b0;
        endcase
    endfunction

    assign rx_op   = bus.i_rx_data[NB_OP-1:0];
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    assign timeout = (cnt == TO_LAST);

    always_comb begin
        state_next    = state;
        cnt_next      = '0;
        data_a_next   = data_a;
        data_b_next   = data_b;
        op_next       = op;
        tx_data_next  = tx_data;
        tx_start_next = 1'b0;
        error_next    = 1'b0;
        case (state)
            WAIT_A: begin
                if (bus.i_rxdone) begin
                    data_a_next = bus.i_rx_data;
                    state_next  = WAIT_B;
                end
            end
            WAIT_B: begin
                if (bus.i_rxdone) begin
                    data_b_next = bus.i_rx_data;
                    state_next  = WAIT_OP;
                end else if (timeout) begin
                    error_next = 1'b1;
                    state_next = WAIT_A;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            WAIT_OP: begin
                if (bus.i_rxdone) begin
                    if (op_valid(rx_op)) begin
                        op_next    = rx_op;
                        state_next = SEND;
                    end else begin
                        error_next = 1'b1;
                        state_next = WAIT_A;
                    end
                end else if (timeout) begin
                    error_next = 1'b1;
                    state_next = WAIT_A;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            SEND: begin
                tx_data_next  = bus.i_alu_result;
                tx_start_next = 1'b1;
                state_next    = WAIT_TX;
            end
            WAIT_TX: begin
                if (bus.i_tx_done) begin
                    state_next = WAIT_A;
                end else if (timeout) begin
                    error_next = 1'b1;
                    state_next = WAIT_A;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: state_next = WAIT_A;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= WAIT_A;
            cnt      <= '0;
            data_a   <= '0;
            data_b   <= '0;
            op       <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            data_a   <= data_a_next;
            data_b   <= data_b_next;
            op       <= op_next;
            tx_data  <= tx_data_next;
            tx_start <= tx_start_next;
            error    <= error_next;
        end
    end

    assign bus.o_data_a   = data_a;
    assign bus.o_data_b   = data_b;
    assign bus.o_op       = op;
    assign bus.o_tx_data  = tx_data;
    assign bus.o_tx_start = tx_start;
    assign bus.o_error    = error;
    assign bus.o_busy     = (state != WAIT_A);

endmodule

// File: tb/tb_uart_alu_if.sv
// Directed frames for uart_alu_if; expected tx/error events are queued by stimulus and
// consumed by a monitor that compares every o_tx_start / o_error pulse against the queue.
module tb_uart_alu_if;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int TO      = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_alu_if_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

    uart_alu_if #(
        .NB_DATA(NB_DATA),
        .NB_OP(NB_OP),
        .TIMEOUT_CYC(TO),
        .NB_TIMEOUT(20)
    ) dut (
        .clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    // Reference ALU driven from the operands the DUT presents.
    always_comb begin
        case (bus.o_op)
            6'b100000: bus.i_alu_result = bus.o_data_a + bus.o_data_b;
            6'b100010: bus.i_alu_result = bus.o_data_a - bus.o_data_b;
            6'b100100: bus.i_alu_result = bus.o_data_a & bus.o_data_b;
            6'b100101: bus.i_alu_result = bus.o_data_a | bus.o_data_b;
            6'b100110: bus.i_alu_result = bus.o_data_a ^ bus.o_data_b;
            6'b100111: bus.i_alu_result = ~(bus.o_data_a | bus.o_data_b);
            6'b000011: bus.i_alu_result = $unsigned($signed(bus.o_data_a) >>> bus.o_data_b);
            6'b000010: bus.i_alu_result = bus.o_data_a >> bus.o_data_b;
            default:   bus.i_alu_result = 8'h00;
        endcase
    end

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        int         exp_cyc;
    } exp_t;

    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit is_err, input logic [7:0] data, input logic [7:0] a,
                        input logic [7:0] b, input logic [5:0] op, input int exp_cyc);
        exp_t e;
        e.is_err  = is_err;
        e.data    = data;
        e.a       = a;
        e.b       = b;
        e.op      = op;
        e.exp_cyc = exp_cyc;
        q.push_back(e);
    endtask

    logic prev_start = 1'b0;
    logic prev_err   = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (bus.o_tx_start || bus.o_error)) begin
            check("pulse_exclusive", {31'b0, bus.o_tx_start & bus.o_error}, 32'd0);
            check("no_back_to_back", {31'b0, (prev_start & bus.o_tx_start) | (prev_err & bus.o_error)}, 32'd0);
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: tx_start=%b error=%b at cycle %0d, expected none",
                         bus.o_tx_start, bus.o_error, cyc);
            end else begin
                e = q.pop_front();
                check("event_kind_error", {31'b0, bus.o_error}, {31'b0, e.is_err});
                check("event_cycle", cyc, e.exp_cyc);
                if (!e.is_err) check("tx_data", {24'b0, bus.o_tx_data}, {24'b0, e.data});
                check("data_a", {24'b0, bus.o_data_a}, {24'b0, e.a});
                check("data_b", {24'b0, bus.o_data_b}, {24'b0, e.b});
                check("op", {26'b0, bus.o_op}, {26'b0, e.op});
            end
        end
        prev_start = rst_n & bus.o_tx_start;
        prev_err   = rst_n & bus.o_error;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        bus.i_rx_data = d;
        bus.i_rxdone  = 1'b1;
        @(posedge clk);
        #1;
        bus.i_rxdone  = 1'b0;
        bus.i_rx_data = ~d;
    endtask

    task automatic pulse_tx_done();
        bus.i_tx_done = 1'b1;
        @(posedge clk);
        #1;
        bus.i_tx_done = 1'b0;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input logic [7:0] res);
        send_byte(a);
        send_byte(b);
        send_byte(opb);
        push(1'b0, res, a, b, opb[5:0], cyc + 1);
        idle(1);
        pulse_tx_done();
        check("busy_after_frame", {31'b0, bus.o_busy}, 32'd0);
    endtask

    task automatic bad_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input logic [5:0] held_op);
        send_byte(a);
        send_byte(b);
        send_byte(opb);
        push(1'b1, 8'h00, a, b, held_op, cyc);
        idle(2);
        check("busy_after_abort", {31'b0, bus.o_busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_a"},   {24'b0, bus.o_data_a}, 32'd0);
        check({tag, "_data_b"},   {24'b0, bus.o_data_b}, 32'd0);
        check({tag, "_op"},       {26'b0, bus.o_op}, 32'd0);
        check({tag, "_tx_data"},  {24'b0, bus.o_tx_data}, 32'd0);
        check({tag, "_tx_start"}, {31'b0, bus.o_tx_start}, 32'd0);
        check({tag, "_error"},    {31'b0, bus.o_error}, 32'd0);
        check({tag, "_busy"},     {31'b0, bus.o_busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.i_rx_data = 8'h00;
        bus.i_rxdone  = 1'b0;
        bus.i_tx_done = 1'b0;
        #2;
        check_all_zero("reset");
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // tx_done while idle has no effect
        pulse_tx_done();
        check("busy_idle_tx_done", {31'b0, bus.o_busy}, 32'd0);

        frame(8'h05, 8'h03, 8'h20, 8'h08);
        bad_op(8'h11, 8'h22, 8'h3F, 6'h20);
        frame(8'h0F, 8'hF0, 8'h24, 8'h00);
        frame(8'h10, 8'h01, 8'hE2, 8'h0F);
        frame(8'hC3, 8'h3C, 8'h25, 8'hFF);
        frame(8'hA5, 8'hFF, 8'h26, 8'h5A);
        frame(8'h0F, 8'h30, 8'h27, 8'hC0);
        frame(8'h80, 8'h02, 8'h03, 8'hE0);
        frame(8'h80, 8'h02, 8'h02, 8'h20);
        bad_op(8'h01, 8'h02, 8'h21, 6'h02);

        // silence in WAIT_B: error 15 cycles after entering it
        send_byte(8'hAA);
        push(1'b1, 8'h00, 8'hAA, 8'h02, 6'h02, cyc + 15);
        idle(20);
        check("busy_after_timeout_b", {31'b0, bus.o_busy}, 32'd0);

        // silence in WAIT_OP
        send_byte(8'h11);
        send_byte(8'h22);
        push(1'b1, 8'h00, 8'h11, 8'h22, 6'h02, cyc + 15);
        idle(20);
        check("busy_after_timeout_op", {31'b0, bus.o_busy}, 32'd0);

        // no tx_done in WAIT_TX
        send_byte(8'h07);
        send_byte(8'h01);
        send_byte(8'h20);
        push(1'b0, 8'h08, 8'h07, 8'h01, 6'h20, cyc + 1);
        push(1'b1, 8'h00, 8'h07, 8'h01, 6'h20, cyc + 16);
        idle(22);
        check("busy_after_timeout_tx", {31'b0, bus.o_busy}, 32'd0);

        // bytes during SEND / WAIT_TX are dropped
        send_byte(8'h09);
        send_byte(8'h03);
        send_byte(8'h22);
        push(1'b0, 8'h06, 8'h09, 8'h03, 6'h22, cyc + 1);
        send_byte(8'h55);
        send_byte(8'h66);
        check("busy_in_wait_tx", {31'b0, bus.o_busy}, 32'd1);
        pulse_tx_done();
        frame(8'h04, 8'h04, 8'h20, 8'h08);

        // tx_done in WAIT_B is ignored
        send_byte(8'h30);
        pulse_tx_done();
        check("busy_wait_b_tx_done", {31'b0, bus.o_busy}, 32'd1);
        send_byte(8'h03);
        send_byte(8'h20);
        push(1'b0, 8'h33, 8'h30, 8'h03, 6'h20, cyc + 1);
        idle(1);
        pulse_tx_done();

        // events landing exactly on the timeout cycle win
        send_byte(8'h40);
        idle(14);
        send_byte(8'h02);
        check("busy_coincident_b", {31'b0, bus.o_busy}, 32'd1);
        idle(14);
        send_byte(8'h20);
        n = cyc;
        push(1'b0, 8'h42, 8'h40, 8'h02, 6'h20, n + 1);
        idle(15);
        pulse_tx_done();
        check("busy_coincident_tx", {31'b0, bus.o_busy}, 32'd0);
        idle(20);

        // asynchronous reset in WAIT_OP
        send_byte(8'h12);
        send_byte(8'h34);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        #7;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        frame(8'h06, 8'h07, 8'h20, 8'h0D);

        // reset during WAIT_TX: frame discarded, no later timeout
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h20);
        push(1'b0, 8'h02, 8'h01, 8'h01, 6'h20, cyc + 1);
        idle(2);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        idle(20);
        check("busy_after_tx_reset", {31'b0, bus.o_busy}, 32'd0);
        frame(8'h03, 8'h04, 8'h20, 8'h07);

        idle(3);
        check("queue_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
